// File: rtl/vrased_mem_arb_clr_if.sv
// Bundles the signals of the scratch-RAM arbiter into one interface.
//
// The slave modport is the arbiter's side and the master modport is the
// environment's side: the CPU and DMA requesters, the vrased clear source
// and the RAM macro.
//
// Handshake semantics:
//   - A requester holds <x>_req high with its wr/addr/wdata stable.
//   - The access is taken in any cycle where <x>_gnt is high. The grant is
//     combinational, so it appears in the same cycle as the request.
//   - A granted read returns data as follows: <x>_rvalid is high for exactly
//     the next cycle, and rd_data holds the word during that cycle.
//   - Writes produce no response.
//   - A request that is not granted is simply not taken. Nothing is queued
//     on the requester's behalf.
interface vrased_mem_arb_clr_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 37
);
  logic                  clr_req;
  logic                  cpu_req;
  logic                  cpu_wr;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic                  dma_req;
  logic                  dma_wr;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  clr_ram;
  logic                  cpu_hold;

  modport slave (
    input  clr_req, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata, mem_rdata,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rd_data,
    output mem_en, mem_wr, mem_addr, mem_wdata, clr_ram, cpu_hold
  );

  modport master (
    output clr_req, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_addr, dma_wdata, mem_rdata,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rd_data,
    input  mem_en, mem_wr, mem_addr, mem_wdata, clr_ram, cpu_hold
  );
endinterface

// File: rtl/vrased_mem_arb_clr.sv
// Owns the single port of the protected scratch RAM.
//
// Clearing:
//   - After reset, and after every clr_req, the block zero-fills words
//     0..DEPTH-1, one write per cycle.
//   - The CPU is held off while the fill is in progress.
//
// Sharing (RUN state):
//   - The port is shared between the CPU and DMA requesters.
//   - Arbitration is round-robin with a combinational grant.
//
// Ports:
//   clk       system clock, posedge
//   reset     synchronous, active-high
//   bus       arbiter side (slave modport), carrying:
//               - clear request
//               - CPU and DMA request/grant/rvalid
//               - shared rd_data
//               - RAM strobes
//               - clr_ram / cpu_hold
//   dbg_state current FSM state (0 = CLEAR, 1 = RUN)
module vrased_mem_arb_clr #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 37,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  vrased_mem_arb_clr_if.slave  bus,
  output logic                 dbg_state
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  rr_last_dma;   // 1: DMA won the last contested or solo grant
  logic                  cpu_rvalid_q;
  logic                  dma_rvalid_q;

  logic run_ok;
  logic cpu_gnt;
  logic dma_gnt;

  // Reset is applied combinationally to the outputs as well. This keeps
  // the port quiet for the whole reset window, not just after the first
  // edge.
  assign run_ok  = !reset && (state == S_RUN) && !bus.clr_req;
  assign cpu_gnt = run_ok && bus.cpu_req && (!bus.dma_req || rr_last_dma);
  assign dma_gnt = run_ok && bus.dma_req && (!bus.cpu_req || !rr_last_dma);

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q && !reset;
  assign bus.dma_rvalid = dma_rvalid_q && !reset;
  assign bus.rd_data    = bus.mem_rdata;
  assign bus.clr_ram    = reset || (state == S_CLEAR);
  assign bus.cpu_hold   = bus.clr_ram;
  assign dbg_state      = state;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!reset) begin
      if (state == S_CLEAR) begin
        bus.mem_en   = 1'b1;
        bus.mem_wr   = 1'b1;
        bus.mem_addr = clr_cnt;
      end else if (cpu_gnt) begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = bus.cpu_wr;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end else if (dma_gnt) begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = bus.dma_wr;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_CLEAR;
      clr_cnt      <= '0;
      rr_last_dma  <= 1'b1;   // CPU wins the first tie
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt && !bus.cpu_wr;
      dma_rvalid_q <= dma_gnt && !bus.dma_wr;
      case (state)
        S_CLEAR: begin
          // A restart wins over completion, so a request landing on the
          // final write still yields a full fresh walk.
          if (bus.clr_req) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
            state   <= S_RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (bus.clr_req) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end else if (cpu_gnt) begin
            rr_last_dma <= 1'b0;
          end else if (dma_gnt) begin
            rr_last_dma <= 1'b1;
          end
        end
        default: begin
          state   <= S_CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/vrased_mem_arb_clr.md
Name: vrased_mem_arb_clr

Overview:
- Owns the single port of the protected scratch RAM (DEPTH x DATA_WIDTH) used by the attestation hardware.
- Zero-fills the whole RAM after every reset and after every violation-triggered clear request.
- Holds the CPU off during the fill, then shares the port between CPU and DMA requesters with round-robin arbitration.
- Sits between the vrased monitor (its violation reset feeds clr_req) and the RAM macro.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 37, RAM word width.
- DEPTH, 2**ADDR_WIDTH, number of words cleared; DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- clr_req  input  1  one-cycle request to re-clear the RAM (from vrased reset/violation).
- cpu_req  input  1  CPU access request.
- cpu_wr  input  1  CPU write (1) / read (0).
- cpu_addr  input  ADDR_WIDTH  CPU address.
- cpu_wdata  input  DATA_WIDTH  CPU write data.
- cpu_gnt  output  1  CPU access accepted this cycle.
- cpu_rvalid  output  1  CPU read data valid on rd_data.
- dma_req, dma_wr, dma_addr, dma_wdata  input  1/1/ADDR_WIDTH/DATA_WIDTH  DMA request; same meaning as the CPU signals.
- dma_gnt  output  1  DMA access accepted.
- dma_rvalid  output  1  DMA read data valid.
- rd_data  output  DATA_WIDTH  read data (shared); equals mem_rdata.
- mem_en, mem_wr  output  1/1  RAM strobe and write enable.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- mem_rdata  input  DATA_WIDTH  RAM read data; 1-cycle latency after mem_en && !mem_wr.
- clr_ram  output  1  clear in progress.
- cpu_hold  output  1  CPU must stall; equals clr_ram.

Behaviour:
- Clock and reset: one clock clk. reset is synchronous, active-high.
- State machine: two states, CLEAR and RUN.
- While reset is high:
  - state = CLEAR, clr_cnt = 0, rr_last = DMA (so the CPU wins the first tie).
  - Registered rvalid flags are 0.
  - clr_ram = cpu_hold = 1.
  - mem_en = 0; gnt = 0.
- CLEAR state:
  - Each cycle with reset low: mem_en = 1, mem_wr = 1, mem_addr = clr_cnt, mem_wdata = 0; then clr_cnt increments.
  - When a write is issued with clr_cnt == DEPTH-1, the next state is RUN and clr_cnt returns to 0.
  - The clear takes exactly DEPTH write cycles after reset falls. clr_ram drops in the cycle after the last write.
  - cpu_gnt = dma_gnt = 0 throughout; requests are ignored, not queued.
  - clr_req during CLEAR restarts the count: next write goes to address 0. The full DEPTH-cycle walk is repeated.
- RUN state:
  - clr_ram = cpu_hold = 0.
  - Grant is combinational, in the same cycle as the request:
    - Only one requester: it is granted.
    - Both requesting: the one not in rr_last is granted.
    - rr_last updates to the granted requester at the clock edge.
  - Granted requester's wr/addr/wdata pass to mem_wr/mem_addr/mem_wdata, with mem_en = 1.
  - No request: mem_en = 0, mem_addr/mem_wdata = 0.
  - A granted read sets the matching rvalid for exactly the next cycle. rd_data = mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back grants to the same requester are allowed every cycle when the other is idle.
- clr_req in RUN:
  - Takes priority over both requests that cycle: both gnt = 0, mem_en = 0.
  - Next state is CLEAR with clr_cnt = 0.
  - An rvalid from a read granted in the previous cycle is still delivered.
- reset mid-clear or mid-RUN: same as initial reset. Any pending rvalid is cleared.
- Unused high addresses (DEPTH < 2**ADDR_WIDTH) are not cleared, but remain accessible in RUN.

Test Plan:
- Reset 2 cycles, then release (DEPTH=256) -> 256 consecutive writes of 0 to addresses 0x00..0xFF. clr_ram and cpu_hold stay high through the last write and drop in the next cycle. No gnt during the clear even with cpu_req=1.
- RUN; CPU writes 0x1_2345_6789 to addr 0x10, then reads 0x10 -> cpu_gnt same cycle as each request. cpu_rvalid exactly 1 cycle after the read grant, with rd_data = 0x1_2345_6789. dma_rvalid = 0.
- RUN; cpu_req and dma_req held high for 4 cycles -> grants alternate CPU, DMA, CPU, DMA (first goes to CPU after reset). Never both high in the same cycle.
- RUN; clr_req asserted together with cpu_req -> cpu_gnt = 0 that cycle. The next 256 cycles are zero-writes. A subsequent read of 0x10 returns 0.
- clr_req pulsed at clr_cnt = 100 during CLEAR -> next write is to address 0. RUN is entered 256 cycles after the pulse.
- reset asserted in the cycle after a DMA read grant -> dma_rvalid = 0. The clear restarts at address 0 after reset falls.
